// File: rtl/seg7_anim_mux.sv
`default_nettype none
// ============================================================================
// Module : seg7_anim_mux
// Brief  : Frame-animated 7-segment pattern generator with a multiplexed
//          one-hot digit scan, pause/single-step and up/down frame order.
// Rev    : 1.0 - initial release
// ============================================================================
module seg7_anim_mux #(
    parameter int               CNT_W     = 24,
    parameter logic [CNT_W-1:0] MAX_COUNT = CNT_W'(10_000_000),
    parameter int               N_DIGITS  = 4,
    parameter int               SCAN_DIV  = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          anim_sel,
    input  logic [7:0]          speed,
    input  logic                pause,
    input  logic                step,
    input  logic                dir,
    output logic [6:0]          segments,
    output logic [N_DIGITS-1:0] digit_en,
    output logic [3:0]          frame,
    output logic                frame_tick
);

    localparam int                  c_DIG_W     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int                  c_SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_DIG_W-1:0]  c_LAST_DIG  = c_DIG_W'(N_DIGITS - 1);
    localparam logic [c_SCAN_W-1:0] c_LAST_SCAN = c_SCAN_W'(SCAN_DIV - 1);

    logic [2:0]          r_anim;
    logic [CNT_W-1:0]    r_presc;
    logic [3:0]          r_frame;
    logic                r_tick;
    logic [c_SCAN_W-1:0] r_scan;
    logic [c_DIG_W-1:0]  r_digit;
    logic [6:0]          r_seg;
    logic [N_DIGITS-1:0] r_den;

    logic [3:0]          w_limit;
    logic [CNT_W-1:0]    w_cmp;
    logic                w_wrap;
    logic                w_adv;
    logic                w_anim_chg;
    logic [3:0]          w_next;
    logic [4:0]          w_disp;
    logic [6:0]          w_glyph;
    logic [N_DIGITS-1:0] w_onehot;

    always_comb begin
        w_limit = 4'd0;
        case (r_anim)
            3'd0:    w_limit = 4'd9;
            3'd1:    w_limit = 4'd5;
            3'd2:    w_limit = 4'd6;
            3'd3:    w_limit = 4'd1;
            default: w_limit = 4'd0;
        endcase
    end

    assign w_cmp      = (speed == 8'd0) ? MAX_COUNT : CNT_W'({speed, 10'b0});
    assign w_wrap     = (r_presc == w_cmp);
    assign w_adv      = pause ? step : w_wrap;
    assign w_anim_chg = (anim_sel != r_anim);

    always_comb begin
        w_next = 4'd0;
        if (dir) begin
            w_next = (r_frame == 4'd0) ? w_limit : r_frame - 4'd1;
        end else begin
            w_next = (r_frame == w_limit) ? 4'd0 : r_frame + 4'd1;
        end
    end

    // A prescaler above a freshly lowered compare free-runs through 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_anim  <= anim_sel;
            r_presc <= '0;
            r_frame <= 4'd0;
            r_tick  <= 1'b0;
        end else if (w_anim_chg) begin
            r_anim  <= anim_sel;
            r_presc <= '0;
            r_frame <= 4'd0;
            r_tick  <= 1'b0;
        end else begin
            if (!pause) begin
                r_presc <= w_wrap ? '0 : r_presc + CNT_W'(1);
            end
            if (r_frame > w_limit) begin
                r_frame <= 4'd0;
                r_tick  <= 1'b0;
            end else if (w_adv) begin
                r_frame <= w_next;
                r_tick  <= 1'b1;
            end else begin
                r_tick  <= 1'b0;
            end
        end
    end

    // Digit k shows the frame k steps ahead of the base frame.
    assign w_disp = (5'(r_frame) + 5'(r_digit)) % (5'(w_limit) + 5'd1);

    always_comb begin
        w_glyph = 7'h00;
        case (r_anim)
            3'd0: begin
                case (w_disp)
                    5'd0:    w_glyph = 7'h3F;
                    5'd1:    w_glyph = 7'h06;
                    5'd2:    w_glyph = 7'h5B;
                    5'd3:    w_glyph = 7'h4F;
                    5'd4:    w_glyph = 7'h66;
                    5'd5:    w_glyph = 7'h6D;
                    5'd6:    w_glyph = 7'h7D;
                    5'd7:    w_glyph = 7'h07;
                    5'd8:    w_glyph = 7'h7F;
                    5'd9:    w_glyph = 7'h6F;
                    default: w_glyph = 7'h00;
                endcase
            end
            3'd1:    w_glyph = 7'(7'd1 << w_disp[2:0]);
            3'd2:    w_glyph = 7'((8'd1 << w_disp[2:0]) - 8'd1);
            3'd3:    w_glyph = (w_disp == 5'd0) ? 7'h7F : 7'h00;
            default: w_glyph = 7'h40;
        endcase
    end

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (c_DIG_W'(i) == r_digit) begin
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan  <= '0;
            r_digit <= '0;
            r_seg   <= 7'h00;
            r_den   <= '0;
        end else begin
            if (r_scan == c_LAST_SCAN) begin
                r_scan  <= '0;
                r_digit <= (r_digit == c_LAST_DIG) ? '0 : r_digit + c_DIG_W'(1);
            end else begin
                r_scan  <= r_scan + c_SCAN_W'(1);
            end
            r_seg <= w_glyph;
            r_den <= w_onehot;
        end
    end

    assign segments   = r_seg;
    assign digit_en   = r_den;
    assign frame      = r_frame;
    assign frame_tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg7_anim_mux.sv
`default_nettype none
// ============================================================================
// Module : tb_seg7_anim_mux
// Brief  : Directed self-checking bench for seg7_anim_mux (MAX_COUNT=9,
//          N_DIGITS=4, SCAN_DIV=3).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_seg7_anim_mux;

    localparam int c_N_DIGITS = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [2:0]            anim_sel;
    logic [7:0]            speed;
    logic                  pause;
    logic                  step;
    logic                  dir;
    logic [6:0]            segments;
    logic [c_N_DIGITS-1:0] digit_en;
    logic [3:0]            frame;
    logic                  frame_tick;

    int n_tests = 0;
    int n_fails = 0;

    always #5 clk = ~clk;

    seg7_anim_mux #(
        .CNT_W     (24),
        .MAX_COUNT (24'd9),
        .N_DIGITS  (c_N_DIGITS),
        .SCAN_DIV  (3)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .anim_sel   (anim_sel),
        .speed      (speed),
        .pause      (pause),
        .step       (step),
        .dir        (dir),
        .segments   (segments),
        .digit_en   (digit_en),
        .frame      (frame),
        .frame_tick (frame_tick)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [2:0] a, input logic [7:0] s, input logic d);
        anim_sel = a;
        speed    = s;
        dir      = d;
        pause    = 1'b0;
        step     = 1'b0;
        reset    = 1'b1;
        cycles(2);
        reset    = 1'b0;
    endtask

    int seq2 [7] = '{0, 5, 4, 3, 2, 1, 0};
    int ef, fp, d, ticks;

    initial begin
        // anim 0 counting up from reset
        do_reset(3'd0, 8'd0, 1'b0);
        check_val("rst_seg",   segments,   0);
        check_val("rst_den",   digit_en,   0);
        check_val("rst_frame", frame,      0);
        check_val("rst_tick",  frame_tick, 0);
        for (int n = 1; n <= 25; n++) begin
            cycles(1);
            ef = (n >= 20) ? 2 : (n >= 10) ? 1 : 0;
            check_val($sformatf("t1_tick@%0d", n),  frame_tick, (n == 10 || n == 20));
            check_val($sformatf("t1_frame@%0d", n), frame, ef);
            if (n == 1) begin
                check_val("t1_first_den", digit_en, 4'h1);
                check_val("t1_first_seg", segments, 7'h3F);
            end
            if (n == 13) begin
                check_val("t1_d0_den", digit_en, 4'h1);
                check_val("t1_d0_seg", segments, 7'h06);
            end
            if (n == 16) begin
                check_val("t1_d1_den", digit_en, 4'h2);
                check_val("t1_d1_seg", segments, 7'h5B);
            end
        end

        // anim 1 counting down, digit rotation and per-digit offset
        do_reset(3'd1, 8'd0, 1'b1);
        for (int n = 1; n <= 60; n++) begin
            cycles(1);
            d  = ((n - 1) / 3) % 4;
            fp = seq2[(n - 1) / 10];
            check_val($sformatf("t2_frame@%0d", n), frame, seq2[n / 10]);
            check_val($sformatf("t2_tick@%0d", n),  frame_tick, (n % 10 == 0));
            check_val($sformatf("t2_den@%0d", n),   digit_en, 1 << d);
            check_val($sformatf("t2_seg@%0d", n),   segments, 1 << ((fp + d) % 6));
        end

        // pause hold, three single steps, then step ignored when running
        do_reset(3'd0, 8'd0, 1'b0);
        cycles(15);
        check_val("t3_pre_frame", frame, 1);
        pause = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            cycles(1);
            check_val($sformatf("t3_hold_frame@%0d", n), frame, 1);
            check_val($sformatf("t3_hold_tick@%0d", n),  frame_tick, 0);
        end
        for (int s = 0; s < 3; s++) begin
            step = 1'b1;
            cycles(1);
            check_val($sformatf("t3_step_frame%0d", s), frame, 2 + s);
            check_val($sformatf("t3_step_tick%0d", s),  frame_tick, 1);
            step = 1'b0;
            cycles(1);
            check_val($sformatf("t3_post_frame%0d", s), frame, 2 + s);
            check_val($sformatf("t3_post_tick%0d", s),  frame_tick, 0);
        end
        pause = 1'b0;
        step  = 1'b1;
        cycles(1);
        check_val("t3_run_step_frame", frame, 4);
        check_val("t3_run_step_tick",  frame_tick, 0);
        step = 1'b0;
        cycles(3);
        check_val("t3_resume_frame", frame, 4);
        check_val("t3_resume_tick",  frame_tick, 0);
        cycles(1);
        check_val("t3_wrap_frame", frame, 5);
        check_val("t3_wrap_tick",  frame_tick, 1);

        // animation change at frame 7 on the same edge as a prescaler wrap
        do_reset(3'd0, 8'd0, 1'b0);
        cycles(79);
        check_val("t4_pre_frame", frame, 7);
        anim_sel = 3'd3;
        for (int n = 80; n <= 110; n++) begin
            cycles(1);
            ef = ((n - 80) / 10) % 2;
            check_val($sformatf("t4_frame@%0d", n), frame, ef);
            check_val($sformatf("t4_tick@%0d", n),  frame_tick, (n >= 90 && (n - 80) % 10 == 0));
            if (n >= 81) begin
                fp = ((n - 81) / 10) % 2;
                d  = ((n - 1) / 3) % 4;
                check_val($sformatf("t4_seg@%0d", n), segments, ((fp + d) % 2 == 0) ? 7'h7F : 7'h00);
            end
        end

        // speed=1 (period 1025) with a reset pulse mid-count
        do_reset(3'd0, 8'd1, 1'b0);
        cycles(500);
        check_val("t5_pre_frame", frame, 0);
        reset = 1'b1;
        cycles(1);
        check_val("t5_rst_seg",   segments,   0);
        check_val("t5_rst_den",   digit_en,   0);
        check_val("t5_rst_frame", frame,      0);
        check_val("t5_rst_tick",  frame_tick, 0);
        reset = 1'b0;
        ticks = 0;
        for (int n = 1; n <= 1024; n++) begin
            cycles(1);
            if (frame_tick === 1'b1) ticks++;
            if (n == 1) check_val("t5_first_den", digit_en, 4'h1);
        end
        check_val("t5_no_early_ticks", ticks, 0);
        check_val("t5_frame_1024",     frame, 0);
        cycles(1);
        check_val("t5_tick_1025",  frame_tick, 1);
        check_val("t5_frame_1025", frame, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
